// File: rtl/sys_array_pkg.sv
// Shared types and helpers for the systolic-array result path.
package sys_array_pkg;

  // Drain controller states: waiting for a result, or streaming one out.
  typedef enum logic {IDLE, STREAM} drain_state_t;

  // Index width for a dimension of w entries, never narrower than one bit.
  function automatic int idx_width(int w);
    int bits;
    bits = $clog2(w);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/sys_array_rise_detect.sv
// Rising-edge detector on a level signal. The history register resets to
// RESET_VAL, so a level that is already high when reset releases can be
// ignored by choosing RESET_VAL = 1.
module sys_array_rise_detect #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic hist_reg;

  // Remember the level seen at the previous edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_reg <= RESET_VAL;
    end else begin
      hist_reg <= in;
    end
  end

  assign rise = in & ~hist_reg;

endmodule

// File: rtl/sys_array_result_drain.sv
// Snapshots the fetcher's ARRAY_W x ARRAY_W result matrix on a rising
// comp_ready and streams it out one element per valid/ready beat.
module sys_array_result_drain
  import sys_array_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter bit COL_MAJOR  = 1'b0
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             comp_ready,
  input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] in_data,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [2*DATA_WIDTH-1:0]                          out_elem,
  output logic [idx_width(ARRAY_W)-1:0]                    out_row,
  output logic [idx_width(ARRAY_W)-1:0]                    out_col,
  output logic                                             out_last,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             overflow
);

  localparam int IDXW = idx_width(ARRAY_W);
  localparam int NUM  = ARRAY_W * ARRAY_W;
  localparam int KW   = idx_width(NUM);
  localparam int EW   = 2 * DATA_WIDTH;
  localparam logic [IDXW-1:0] IDX_MAX = IDXW'(ARRAY_W - 1);
  localparam logic [KW-1:0]   K_MAX   = KW'(NUM - 1);

  drain_state_t   state_reg, state_next;
  logic [KW-1:0]   k_reg, k_next;
  logic [IDXW-1:0] row_reg, row_next;
  logic [IDXW-1:0] col_reg, col_next;
  logic [EW-1:0]   elem_reg, elem_next;
  logic            last_reg, last_next;
  logic            done_reg, done_next;
  logic            overflow_reg, overflow_next;

  logic            capture;
  logic            beat;
  logic            restart;
  logic            load;

  // The buffer is stored in stream order, so draining is a plain counter walk
  // regardless of COL_MAJOR.
  logic [EW-1:0] ordered [NUM];
  logic [EW-1:0] buf_reg [NUM];

  genvar gi;
  generate
    for (gi = 0; gi < NUM; gi++) begin : g_order
      localparam int R = COL_MAJOR ? (gi % ARRAY_W) : (gi / ARRAY_W);
      localparam int C = COL_MAJOR ? (gi / ARRAY_W) : (gi % ARRAY_W);
      assign ordered[gi] = in_data[R][C];
    end
  endgenerate

  // A comp_ready already high at reset release must not look like a new result.
  sys_array_rise_detect #(
    .RESET_VAL(1'b1)
  ) u_rise (
    .clk  (clk),
    .reset(reset),
    .in   (comp_ready),
    .rise (capture)
  );

  assign beat    = (state_reg == STREAM) && out_ready;
  assign restart = capture && ((state_reg == IDLE) || (beat && last_reg));

  // Snapshot the whole matrix whenever a new stream starts.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM; i++) begin
        buf_reg[i] <= ordered[i];
      end
    end
  end

  // Next-state, index advance and output-register update.
  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    row_next      = row_reg;
    col_next      = col_reg;
    elem_next     = elem_reg;
    last_next     = last_reg;
    done_next     = 1'b0;
    overflow_next = overflow_reg;
    load          = 1'b0;

    case (state_reg)
      IDLE: begin
        // Only a capture leaves IDLE; handled by the restart path below.
      end
      STREAM: begin
        if (beat && last_reg) begin
          done_next  = 1'b1;
          state_next = IDLE;
          last_next  = 1'b0;
        end else begin
          // A result arriving mid-stream cannot be held; flag and drop it.
          if (capture) begin
            overflow_next = 1'b1;
          end
          if (beat) begin
            k_next    = k_reg + KW'(1);
            elem_next = buf_reg[k_next];
            last_next = (k_next == K_MAX);
            if (COL_MAJOR) begin
              if (row_reg == IDX_MAX) begin
                row_next = '0;
                col_next = col_reg + IDXW'(1);
              end else begin
                row_next = row_reg + IDXW'(1);
              end
            end else begin
              if (col_reg == IDX_MAX) begin
                col_next = '0;
                row_next = row_reg + IDXW'(1);
              end else begin
                col_next = col_reg + IDXW'(1);
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // New stream from IDLE, or back-to-back with the final beat of the last one.
    if (restart) begin
      load       = 1'b1;
      state_next = STREAM;
      k_next     = '0;
      row_next   = '0;
      col_next   = '0;
      elem_next  = ordered[0];
      last_next  = (NUM == 1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      row_reg      <= '0;
      col_reg      <= '0;
      elem_reg     <= '0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      elem_reg     <= elem_next;
      last_reg     <= last_next;
      done_reg     <= done_next;
      overflow_reg <= overflow_next;
    end
  end

  assign out_valid = (state_reg == STREAM);
  assign busy      = (state_reg == STREAM);
  assign out_elem  = elem_reg;
  assign out_row   = row_reg;
  assign out_col   = col_reg;
  assign out_last  = last_reg;
  assign done      = done_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_sys_array_result_drain.sv
// Bench for sys_array_result_drain: a row-major and a column-major instance
// share all stimulus and are each checked against an order model.
module tb_sys_array_result_drain;

  localparam int W   = 5;
  localparam int DW  = 8;
  localparam int NUM = W * W;

  logic clk = 1'b0;
  logic reset;
  logic comp_ready;
  logic out_ready;
  logic [0:W-1][0:W-1][2*DW-1:0] in_data;

  logic          rm_valid, rm_last, rm_busy, rm_done, rm_ovf;
  logic [15:0]   rm_elem;
  logic [2:0]    rm_row, rm_col;
  logic          cm_valid, cm_last, cm_busy, cm_done, cm_ovf;
  logic [15:0]   cm_elem;
  logic [2:0]    cm_row, cm_col;

  int n_tests = 0;
  int n_fail  = 0;

  int mat [W][W];
  int q_rm_v[$], q_rm_r[$], q_rm_c[$];
  int q_cm_v[$], q_cm_r[$], q_cm_c[$];

  always #5 clk = ~clk;

  sys_array_result_drain #(.DATA_WIDTH(DW), .ARRAY_W(W), .COL_MAJOR(1'b0)) dut_rm (
    .clk(clk), .reset(reset), .comp_ready(comp_ready), .in_data(in_data),
    .out_valid(rm_valid), .out_ready(out_ready), .out_elem(rm_elem),
    .out_row(rm_row), .out_col(rm_col), .out_last(rm_last),
    .busy(rm_busy), .done(rm_done), .overflow(rm_ovf)
  );

  sys_array_result_drain #(.DATA_WIDTH(DW), .ARRAY_W(W), .COL_MAJOR(1'b1)) dut_cm (
    .clk(clk), .reset(reset), .comp_ready(comp_ready), .in_data(in_data),
    .out_valid(cm_valid), .out_ready(out_ready), .out_elem(cm_elem),
    .out_row(cm_row), .out_col(cm_col), .out_last(cm_last),
    .busy(cm_busy), .done(cm_done), .overflow(cm_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_mat();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        in_data[r][c] = 16'(mat[r][c]);
  endtask

  // Expected streams: row-major walks rows outermost, column-major walks columns.
  task automatic build_exp();
    q_rm_v.delete(); q_rm_r.delete(); q_rm_c.delete();
    q_cm_v.delete(); q_cm_r.delete(); q_cm_c.delete();
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++) begin
        q_rm_v.push_back(mat[r][c]); q_rm_r.push_back(r); q_rm_c.push_back(c);
      end
    for (int c = 0; c < W; c++)
      for (int r = 0; r < W; r++) begin
        q_cm_v.push_back(mat[r][c]); q_cm_r.push_back(r); q_cm_c.push_back(c);
      end
  endtask

  task automatic set_mat_base(input int base);
    for (int r = 0; r < W; r++)
      for (int c = 0; c < W; c++)
        mat[r][c] = base + 10 * r + c;
  endtask

  task automatic do_reset();
    reset = 1'b1; comp_ready = 1'b0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  // Raise comp_ready for one edge; the first beat is visible afterwards.
  task automatic start_capture(input bit hold_high);
    comp_ready = 1'b1;
    step();
    if (!hold_high) comp_ready = 1'b0;
  endtask

  // Walk a stream, checking every presented beat (stalled or not).
  // evt_kind: 0 none, 1 mid-stream capture of 99s, 2 capture on last beat,
  // 3 one-cycle reset while beat evt_beat is presented.
  task automatic run_stream(input string tag, input bit rand_ready,
                            input int evt_beat, input int evt_kind);
    int  i;
    int  cyc;
    bit  stop;
    i = 0; cyc = 0; stop = 0;
    while (i < NUM && cyc < 400 && !stop) begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (i == evt_beat && evt_kind == 1) begin
        comp_ready = 1'b1;
        for (int r = 0; r < W; r++)
          for (int c = 0; c < W; c++) in_data[r][c] = 16'd99;
      end
      if (i == evt_beat && evt_kind == 2) begin
        out_ready  = 1'b1;
        comp_ready = 1'b1;
        for (int r = 0; r < W; r++)
          for (int c = 0; c < W; c++) in_data[r][c] = 16'(100 + 10 * r + c);
      end
      chk({tag, "/rm_valid"}, 32'(rm_valid), 1);
      chk({tag, "/rm_busy"},  32'(rm_busy),  1);
      chk({tag, "/rm_elem"},  32'(rm_elem),  q_rm_v[i]);
      chk({tag, "/rm_row"},   32'(rm_row),   q_rm_r[i]);
      chk({tag, "/rm_col"},   32'(rm_col),   q_rm_c[i]);
      chk({tag, "/rm_last"},  32'(rm_last),  (i == NUM - 1) ? 1 : 0);
      chk({tag, "/cm_elem"},  32'(cm_elem),  q_cm_v[i]);
      chk({tag, "/cm_row"},   32'(cm_row),   q_cm_r[i]);
      chk({tag, "/cm_col"},   32'(cm_col),   q_cm_c[i]);
      chk({tag, "/cm_last"},  32'(cm_last),  (i == NUM - 1) ? 1 : 0);
      if (cyc > 0) begin
        chk({tag, "/rm_done_mid"}, 32'(rm_done), 0);
        chk({tag, "/cm_done_mid"}, 32'(cm_done), 0);
      end
      if (i == evt_beat && evt_kind == 3) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        stop  = 1;
      end else begin
        if (out_ready) i++;
        step();
        cyc++;
      end
    end
    out_ready = 1'b1;
    if (!stop) begin
      chk({tag, "/beats"}, 32'(i), NUM);
      if (evt_kind != 2) begin
        chk({tag, "/rm_done"},  32'(rm_done),  1);
        chk({tag, "/cm_done"},  32'(cm_done),  1);
        chk({tag, "/rm_idle"},  32'(rm_valid), 0);
        chk({tag, "/cm_idle"},  32'(cm_valid), 0);
        chk({tag, "/rm_busy0"}, 32'(rm_busy),  0);
        step();
        chk({tag, "/rm_done_off"}, 32'(rm_done), 0);
        chk({tag, "/cm_done_off"}, 32'(cm_done), 0);
      end
    end
    $display("[TB] %s: stream walked (%0d beats, %0d cycles)", tag, i, cyc);
  endtask

  initial begin
    reset = 1'b1; comp_ready = 1'b0; out_ready = 1'b1;
    set_mat_base(0);
    apply_mat();

    // Reset state
    do_reset();
    chk("reset/valid", 32'(rm_valid), 0);
    chk("reset/busy",  32'(rm_busy),  0);
    chk("reset/done",  32'(rm_done),  0);
    chk("reset/ovf",   32'(rm_ovf),   0);
    chk("reset/elem",  32'(rm_elem),  0);
    chk("reset/row",   32'(rm_row),   0);
    chk("reset/col",   32'(rm_col),   0);
    chk("reset/last",  32'(rm_last),  0);

    // 1 and 6: full-rate drain, both orders
    set_mat_base(0); apply_mat(); build_exp();
    start_capture(1'b0);
    run_stream("t1", 1'b0, -1, 0);
    chk("t1/rm_ovf", 32'(rm_ovf), 0);

    // 2: random back-pressure, same sequence
    start_capture(1'b0);
    run_stream("t2", 1'b1, -1, 0);
    chk("t2/rm_ovf", 32'(rm_ovf), 0);

    // 3: second result at beat 10 is dropped
    do_reset();
    set_mat_base(0); apply_mat(); build_exp();
    start_capture(1'b0);
    run_stream("t3", 1'b0, 10, 1);
    chk("t3/rm_ovf", 32'(rm_ovf), 1);
    chk("t3/cm_ovf", 32'(cm_ovf), 1);

    // 4: new result coincident with last handshake restarts the stream
    do_reset();
    set_mat_base(0); apply_mat(); build_exp();
    start_capture(1'b0);
    run_stream("t4", 1'b0, NUM - 1, 2);
    chk("t4/rm_done",  32'(rm_done),  1);
    chk("t4/rm_valid", 32'(rm_valid), 1);
    chk("t4/rm_elem",  32'(rm_elem),  100);
    chk("t4/rm_row",   32'(rm_row),   0);
    chk("t4/rm_col",   32'(rm_col),   0);
    chk("t4/rm_ovf",   32'(rm_ovf),   0);
    chk("t4/cm_elem",  32'(cm_elem),  100);
    comp_ready = 1'b0;
    set_mat_base(100); build_exp();
    run_stream("t4b", 1'b0, -1, 0);
    chk("t4b/rm_ovf", 32'(rm_ovf), 0);

    // 5: reset at beat 7 with comp_ready held high
    do_reset();
    set_mat_base(0); apply_mat(); build_exp();
    start_capture(1'b1);
    run_stream("t5", 1'b0, 7, 3);
    chk("t5/valid_after_rst", 32'(rm_valid), 0);
    chk("t5/done_after_rst",  32'(rm_done),  0);
    chk("t5/cm_valid_after",  32'(cm_valid), 0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5/no_capture", 32'(rm_valid), 0);
      chk("t5/no_done",    32'(rm_done),  0);
    end
    comp_ready = 1'b0;
    step();
    start_capture(1'b0);
    run_stream("t5b", 1'b0, -1, 0);

    // Random matrices under random back-pressure
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < W; r++)
        for (int c = 0; c < W; c++)
          mat[r][c] = int'($urandom_range(0, 65535));
      apply_mat(); build_exp();
      start_capture(1'b0);
      run_stream("rand", 1'b1, -1, 0);
    end
    chk("rand/ovf", 32'(rm_ovf), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
